hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Sequencer for the four-stage pipeline register bank (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates every enable and flush the bank and PC need: global WEN, ifid_WEN, ifid_FLUSH, an ID/EX bubble select, and pc_WEN.
- Arbitrates halt, data-memory wait, taken branch, load-use hazard and instruction-fetch miss, in fixed priority.
- Holds a fetch that completed during a stall so it is not re-requested, and latches a sticky halt.

Parameters:
- REG_W, 5, register-address width for hazard compares.
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction memory returned a valid instruction this cycle.
- dhit  in  1  data memory completed the EX/MEM access this cycle.
- dmem_req  in  1  EX/MEM holds a load or store.
- branch_taken  in  1  branch resolved taken in EX/MEM.
- halt  in  1  MEM/WB holds a halt instruction.
- idex_memread  in  1  ID/EX holds a load.
- idex_rd  in  REG_W  ID/EX destination register.
- ifid_rs, ifid_rt  in  REG_W each  IF/ID source registers.
- WEN  out  1  enable for the ID/EX, EX/MEM and MEM/WB registers.
- ifid_WEN  out  1  IF/ID load.
- ifid_FLUSH  out  1  IF/ID clear. Effective only while ifid_WEN=0.
- idex_FLUSH  out  1  selects the zero bubble into idex_n.
- pc_WEN  out  1  PC update.
- halted  out  1  sticky halt indication.
- stall_cycles  out  CNT_W  performance counter.
- flush_count  out  CNT_W  performance counter.

Behaviour:
- State register: RUN, MEMWAIT, HALTED. Also a 1-bit register ihit_held.
- Reset (RST=1 at an edge): state=RUN, ihit_held=0, counters=0.
- While RST=1, all enables and flushes are forced to 0 and halted=0.
- Outputs are combinational from state, ihit_held and inputs.
- fetch_ok = ihit | ihit_held.
- loaduse = idex_memread & (idex_rd!=0) & (idex_rd==ifid_rs | idex_rd==ifid_rt).
- Priority in RUN/MEMWAIT (first match wins):
  1. halt: all enables and flushes 0; next state HALTED.
  2. dmem_req & ~dhit: all enables and flushes 0; next state MEMWAIT; ihit_held <= ihit_held | ihit.
  3. branch_taken: WEN=1, ifid_WEN=0, ifid_FLUSH=1, idex_FLUSH=1, pc_WEN=1; ihit_held <= 0; next state RUN.
  4. loaduse: WEN=1, ifid_WEN=0, ifid_FLUSH=0, idex_FLUSH=1, pc_WEN=0; ihit_held <= fetch_ok; next state RUN.
  5. ~fetch_ok: WEN=1, ifid_WEN=0, ifid_FLUSH=1, idex_FLUSH=0, pc_WEN=0; next state RUN.
  6. Otherwise: WEN=1, ifid_WEN=1, pc_WEN=1, flushes 0; ihit_held <= 0; next state RUN.
- The cycle in which dhit arrives is evaluated by rules 3-6 (zero extra latency). MEMWAIT only records the wait.
- HALTED: all enables and flushes 0, halted=1. Left only by reset; every input is ignored.
- ifid_WEN and ifid_FLUSH are never both 1.
- Load-use inserts exactly one bubble: the next cycle's ID/EX holds memread=0.
- A taken branch overrides a simultaneous load-use or fetch miss, and discards any held fetch.
- Reset asserted mid-MEMWAIT: the next cycle is RUN with ihit_held=0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments in every non-reset cycle where pc_WEN=0 and state is not HALTED. flush_count increments on every rule-3 cycle. Both wrap modulo 2^CNT_W.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset then ihit=1, no hazards for 3 cycles -> WEN=ifid_WEN=pc_WEN=1, flushes 0, halted=0 every cycle.
- idex_memread=1, idex_rd=3, ifid_rs=3, ihit=1 -> one cycle of idex_FLUSH=1, pc_WEN=0, ifid_WEN=0. Next cycle (memread=0, ihit=0): ifid_WEN=1, pc_WEN=1 via ihit_held. Repeat with idex_rd=0 -> no stall.
- dmem_req=1, dhit=0 for 3 cycles with ihit pulsed in cycle 2, then dhit=1 with ihit=0 -> WEN=0 for 3 cycles, state MEMWAIT; in the dhit cycle WEN=ifid_WEN=pc_WEN=1.
- branch_taken=1 together with loaduse=1 and ihit=0 -> ifid_FLUSH=1, idex_FLUSH=1, pc_WEN=1, ifid_WEN=0; flush_count 0->1.
- halt=1 -> all enables 0; halted=1 from the next cycle. Toggle all inputs for 5 cycles -> no change. RST=1 for one edge -> RUN, counters=0.
- With HAZARD_PERF_CNT_EN, 4 fetch-miss cycles -> stall_cycles=4. Without the macro -> stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard sequencer. Generates the enables and flushes for
//            the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
//            Optional macro HAZARD_PERF_CNT_EN builds the stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             branch_taken,
    input  logic             halt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    output logic             WEN,
    output logic             ifid_WEN,
    output logic             ifid_FLUSH,
    output logic             idex_FLUSH,
    output logic             pc_WEN,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ihit_held_q, ihit_held_d;

    logic   w_fetch_ok;
    logic   w_loaduse;
    logic   w_branch_sel;
    logic   wen_d, ifid_wen_d, ifid_flush_d, idex_flush_d, pc_wen_d;

    assign w_fetch_ok = ihit | ihit_held_q;
    assign w_loaduse  = idex_memread && (idex_rd != '0) &&
                        ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            ihit_held_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ihit_held_q <= ihit_held_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ihit_held_d  = ihit_held_q;
        wen_d        = 1'b0;
        ifid_wen_d   = 1'b0;
        ifid_flush_d = 1'b0;
        idex_flush_d = 1'b0;
        pc_wen_d     = 1'b0;
        w_branch_sel = 1'b0;
        if (state_q != HALTED) begin
            // Fixed priority; a completing dhit falls through to the lower rules.
            if (halt) begin
                state_d = HALTED;
            end else if (dmem_req && !dhit) begin
                state_d     = MEMWAIT;
                ihit_held_d = ihit_held_q | ihit;
            end else if (branch_taken) begin
                state_d      = RUN;
                w_branch_sel = 1'b1;
                wen_d        = 1'b1;
                ifid_flush_d = 1'b1;
                idex_flush_d = 1'b1;
                pc_wen_d     = 1'b1;
                ihit_held_d  = 1'b0;
            end else if (w_loaduse) begin
                state_d      = RUN;
                wen_d        = 1'b1;
                idex_flush_d = 1'b1;
                ihit_held_d  = w_fetch_ok;
            end else if (!w_fetch_ok) begin
                state_d      = RUN;
                wen_d        = 1'b1;
                ifid_flush_d = 1'b1;
            end else begin
                state_d     = RUN;
                wen_d       = 1'b1;
                ifid_wen_d  = 1'b1;
                pc_wen_d    = 1'b1;
                ihit_held_d = 1'b0;
            end
        end
    end

    assign WEN        = wen_d        & ~RST;
    assign ifid_WEN   = ifid_wen_d   & ~RST;
    assign ifid_FLUSH = ifid_flush_d & ~RST;
    assign idex_FLUSH = idex_flush_d & ~RST;
    assign pc_WEN     = pc_wen_d     & ~RST;
    assign halted     = (state_q == HALTED) & ~RST;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_wen_d && (state_q != HALTED))
                stall_cycles_q <= stall_cycles_q + 1'b1;
            if (w_branch_sel)
                flush_count_q <= flush_count_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             CLK;
    logic             RST;
    logic             ihit, dhit, dmem_req, branch_taken, halt, idex_memread;
    logic [REG_W-1:0] idex_rd, ifid_rs, ifid_rt;
    logic             WEN, ifid_WEN, ifid_FLUSH, idex_FLUSH, pc_WEN, halted;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .dhit        (dhit),
        .dmem_req    (dmem_req),
        .branch_taken(branch_taken),
        .halt        (halt),
        .idex_memread(idex_memread),
        .idex_rd     (idex_rd),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .WEN         (WEN),
        .ifid_WEN    (ifid_WEN),
        .ifid_FLUSH  (ifid_FLUSH),
        .idex_FLUSH  (idex_FLUSH),
        .pc_WEN      (pc_WEN),
        .halted      (halted),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output vector order: {WEN, ifid_WEN, ifid_FLUSH, idex_FLUSH, pc_WEN, halted}
    localparam logic [5:0] O_RUN   = 6'b110010;
    localparam logic [5:0] O_LU    = 6'b100100;
    localparam logic [5:0] O_MISS  = 6'b101000;
    localparam logic [5:0] O_BR    = 6'b101110;
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_HALT  = 6'b000001;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ih, input logic dh, input logic dreq,
                         input logic br, input logic hl, input logic mr,
                         input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs,
                         input logic [REG_W-1:0] rt);
        RST = rst; ihit = ih; dhit = dh; dmem_req = dreq; branch_taken = br;
        halt = hl; idex_memread = mr; idex_rd = rd; ifid_rs = rs; ifid_rt = rt;
        #2;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {WEN, ifid_WEN, ifid_FLUSH, idex_FLUSH, pc_WEN, halted};
    endfunction

    initial begin
        // Reset: everything forced low
        drive(1, 1, 1, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3);
        chk("rst_outs", 32'(outs()), 32'(O_IDLE));
        tick();
        chk("rst_stall", stall_cycles, 0);
        chk("rst_flush", flush_count, 0);

        // Plain run
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
            chk("run", 32'(outs()), 32'(O_RUN));
            tick();
        end

        // Load-use on rs with ihit -> held fetch releases next cycle
        drive(0, 1, 0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd7);
        chk("lu_rs", 32'(outs()), 32'(O_LU));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3, 5'd7);
        chk("lu_held", 32'(outs()), 32'(O_RUN));
        tick();
        // rd = 0 never stalls
        drive(0, 1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        chk("lu_rd0", 32'(outs()), 32'(O_RUN));
        tick();
        // Load-use on rt
        drive(0, 1, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5);
        chk("lu_rt", 32'(outs()), 32'(O_LU));
        tick();
        drive(0, 1, 0, 0, 0, 0, 0, 5'd5, 5'd1, 5'd5);
        chk("lu_rt_rel", 32'(outs()), 32'(O_RUN));
        tick();
        chk("stall_a", stall_cycles, PERF ? 32'd2 : 32'd0);

        // Data memory wait, ihit pulsed in the second cycle
        for (int i = 0; i < 3; i++) begin
            drive(0, (i == 1), 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
            chk("dwait", 32'(outs()), 32'(O_IDLE));
            tick();
        end
        drive(0, 0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("dhit", 32'(outs()), 32'(O_RUN));
        tick();
        chk("stall_b", stall_cycles, PERF ? 32'd5 : 32'd0);

        // Held fetch discarded by a taken branch overriding load-use
        drive(0, 1, 0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0);
        chk("lu_hold", 32'(outs()), 32'(O_LU));
        tick();
        chk("flush_pre", flush_count, 0);
        drive(0, 0, 0, 0, 1, 0, 1, 5'd3, 5'd3, 5'd0);
        chk("branch", 32'(outs()), 32'(O_BR));
        tick();
        chk("flush_post", flush_count, PERF ? 32'd1 : 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("br_discard", 32'(outs()), 32'(O_MISS));
        tick();
        chk("stall_c", stall_cycles, PERF ? 32'd7 : 32'd0);

        // Halt is sticky and ignores all inputs
        drive(0, 1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        chk("halt", 32'(outs()), 32'(O_IDLE));
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, i[0], ~i[0], 1, i[1], ~i[1], 1, 5'd3, 5'd3, 5'd3);
            chk("halted", 32'(outs()), 32'(O_HALT));
            tick();
        end
        chk("stall_h", stall_cycles, PERF ? 32'd8 : 32'd0);
        chk("flush_h", flush_count, PERF ? 32'd1 : 32'd0);
        drive(1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("rst_halt", 32'(outs()), 32'(O_IDLE));
        tick();
        drive(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("post_rst", 32'(outs()), 32'(O_RUN));
        chk("post_rst_stall", stall_cycles, 0);
        chk("post_rst_flush", flush_count, 0);
        tick();

        // Reset during MEMWAIT drops the held fetch
        drive(0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("mw_hold", 32'(outs()), 32'(O_IDLE));
        tick();
        drive(1, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
            chk("miss", 32'(outs()), 32'(O_MISS));
            tick();
        end
        chk("stall_miss", stall_cycles, PERF ? 32'd4 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
